// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and types for the fetch stage
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT         = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP                = 32'h0000_0013;
  localparam int          FETCH_FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch queue with push, pop, flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> ((count != CNT_FULL) || pop));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage: PC, credit-limited imem requests, response queue, redirect flush
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] DEPTH_LIM = CW'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [31:0]   redirect_target;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  // Every in-flight request owns a queue slot, so responses can never overflow the queue.
  assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid  = rst_n && !redirect_valid && (credit_used < {1'b0, DEPTH_LIM});
  assign imem_req_addr   = pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = align_word(redirect_pc);

  assign fifo_push = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
  assign fifo_pop  = if_valid && if_ready;
  assign wr_entry  = '{pc: resp_pc_q, instr: imem_resp_data};

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !imem_resp_valid)      outstanding_nxt = outstanding + ONE;
    else if (!req_fire && imem_resp_valid) outstanding_nxt = outstanding - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Whatever is still in flight after this cycle belongs to the wrong path.
        pc_q      <= redirect_target;
        resp_pc_q <= redirect_target;
        drop_cnt  <= outstanding_nxt;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (imem_resp_valid) begin
          if (drop_cnt != '0) drop_cnt  <= drop_cnt - ONE;
          else                resp_pc_q <= resp_pc_q + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign if_valid       = !fifo_empty;
  assign if_instruction = head_entry.instr;
  assign if_pc          = head_entry.pc;

  a_counters: assert property (@(posedge clk) disable iff (!rst_n)
    (drop_cnt <= outstanding) && (outstanding <= DEPTH_LIM));
  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outstanding != '0));

endmodule
